// File: rtl/exu_muldiv_if.sv
// Request/writeback bundle for the RV32M iterative multiply/divide unit.
// The slave side is the unit; the master side is decode plus writeback.
interface exu_muldiv_if #(
  parameter int XLEN = 32
) ();
  logic            i_valid;
  logic            o_ready;
  logic [7:0]      i_op;
  logic [XLEN-1:0] i_rs1;
  logic [XLEN-1:0] i_rs2;
  logic [4:0]      i_rdidx;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_wbck_wdat;
  logic [4:0]      o_wbck_rdidx;

  modport slave (
    input  i_valid, i_op, i_rs1, i_rs2, i_rdidx, i_ready,
    output o_ready, o_valid, o_wbck_wdat, o_wbck_rdidx
  );

  modport master (
    output i_valid, i_op, i_rs1, i_rs2, i_rdidx, i_ready,
    input  o_ready, o_valid, o_wbck_wdat, o_wbck_rdidx
  );
endinterface

// File: rtl/exu_muldiv.sv
// RV32M multiply/divide: radix-2 shift-add multiply, restoring divide,
// both on operand magnitudes with a final sign fix.
module exu_muldiv #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  output logic          o_busy,
  exu_muldiv_if.slave   bus
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PREP = 3'd1;
  localparam logic [2:0] ITER = 3'd2;
  localparam logic [2:0] FIX  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [2:0]        state;
  logic [4:0]        cnt;
  logic [7:0]        op_q;
  logic [XLEN-1:0]   rs1_q;
  logic [XLEN-1:0]   rs2_q;
  logic [XLEN-1:0]   wdat_q;
  logic [2*XLEN-1:0] p;
  logic              neg_q;
  logic [4:0]        rdidx_q;

  logic [7:0] op_lo;
  logic is_mul, is_mulh, is_mulhsu, is_mulhu;
  logic is_div, is_divu, is_rem, is_remu;
  logic mul_grp, rem_grp;
  logic neg1, neg2, neg_res, div0, ovf;
  logic [XLEN-1:0] mag1, mag2;

  always_comb begin
    op_lo     = op_q & (~op_q + 8'd1);
    is_mul    = op_lo[0] | ~|op_q;
    is_mulh   = op_lo[1];
    is_mulhsu = op_lo[2];
    is_mulhu  = op_lo[3];
    is_div    = op_lo[4];
    is_divu   = op_lo[5];
    is_rem    = op_lo[6];
    is_remu   = op_lo[7];
    mul_grp   = is_mul | is_mulh | is_mulhsu | is_mulhu;
    rem_grp   = is_rem | is_remu;
    neg1 = (is_mul | is_mulh | is_mulhsu | is_div | is_rem)
         & rs1_q[XLEN-1];
    neg2 = (is_mul | is_mulh | is_div | is_rem)
         & rs2_q[XLEN-1];
    mag1    = neg1 ? -rs1_q : rs1_q;
    mag2    = neg2 ? -rs2_q : rs2_q;
    neg_res = rem_grp ? neg1 : (neg1 ^ neg2);
    div0    = ~mul_grp & (rs2_q == '0);
    ovf     = (is_div | is_rem) & (rs1_q == SMIN)
            & (rs2_q == '1);
  end

  // p holds {acc_hi, multiplier} or {remainder, dividend/quotient}
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN:0]     div_sh;
  logic              div_ge;
  logic [XLEN-1:0]   rem_sub;
  logic [2*XLEN-1:0] div_nxt;

  always_comb begin
    mul_sum = {1'b0, p[2*XLEN-1:XLEN]}
            + (p[0] ? {1'b0, rs2_q} : '0);
    mul_nxt = {mul_sum, p[XLEN-1:1]};
    div_sh  = {p[2*XLEN-1:XLEN], p[XLEN-1]};
    div_ge  = div_sh >= {1'b0, rs2_q};
    rem_sub = div_sh[XLEN-1:0] - rs2_q;
    div_nxt = {div_ge ? rem_sub : div_sh[XLEN-1:0],
               p[XLEN-2:0], div_ge};
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rmd;
  logic [XLEN-1:0]   res;

  always_comb begin
    prod = neg_q ? -p : p;
    quo  = neg_q ? -p[XLEN-1:0] : p[XLEN-1:0];
    rmd  = neg_q ? -p[2*XLEN-1:XLEN] : p[2*XLEN-1:XLEN];
    if (is_mul)       res = prod[XLEN-1:0];
    else if (mul_grp) res = prod[2*XLEN-1:XLEN];
    else if (rem_grp) res = rmd;
    else              res = quo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      wdat_q  <= '0;
      p       <= '0;
      neg_q   <= 1'b0;
      rdidx_q <= '0;
    end else if (i_flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (bus.i_valid) begin
          op_q    <= bus.i_op;
          rs1_q   <= bus.i_rs1;
          rs2_q   <= bus.i_rs2;
          rdidx_q <= bus.i_rdidx;
          state   <= PREP;
        end
        PREP: begin
          p     <= {{XLEN{1'b0}}, mag1};
          rs2_q <= mag2;
          neg_q <= neg_res;
          cnt   <= 5'd31;
          if (div0) begin
            wdat_q <= rem_grp ? rs1_q : '1;
            state  <= DONE;
          end else if (ovf) begin
            wdat_q <= is_div ? SMIN : '0;
            state  <= DONE;
          end else begin
            state <= ITER;
          end
        end
        ITER: begin
          p   <= mul_grp ? mul_nxt : div_nxt;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) state <= FIX;
        end
        FIX: begin
          wdat_q <= res;
          state  <= DONE;
        end
        DONE: if (bus.i_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_ready      = (state == IDLE);
  assign bus.o_valid      = (state == DONE) & ~i_flush;
  assign bus.o_wbck_wdat  = wdat_q;
  assign bus.o_wbck_rdidx = rdidx_q;
  assign o_busy           = (state != IDLE);
endmodule
